// File: rtl/product_bcd_converter_pkg.sv
// Shared definitions for the product-to-BCD converter.
// Holds the FSM state encoding and the default sizing constants that the
// converter top and its bench agree on.
package product_bcd_converter_pkg;

    // Default sizing: a 16-bit product needs 5 decimal digits (65535 < 10^5).
    localparam int unsigned DEF_WIDTH  = 16;
    localparam int unsigned DEF_DIGITS = 5;
    localparam int unsigned DEF_CNT_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/product_bcd_converter_bcd_digit_adj.sv
// Double-dabble digit correction.
// Adds 3 to a BCD digit that is 5 or more, so that the following left shift
// carries correctly into the next decimal digit.
// Ports:
//   digit_in  - 4-bit BCD digit before correction
//   digit_out - corrected digit, ready to be shifted
module bcd_digit_adj (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= 4'd5) begin
            digit_out = digit_in + 4'd3;
        end
    end

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter for the 8x8 multiplier product.
// Captures product_in on the rising edge of the multiplier's done level and
// runs one shift-add-3 step per clock, presenting DIGITS packed BCD digits
// with a one-cycle valid pulse. A capture that arrives while a conversion is
// running is parked in a one-deep pending slot; overwriting that slot sets
// the sticky overrun flag.
// Ports:
//   clk        - system clock, rising edge
//   reset_a    - asynchronous active-high reset
//   done       - multiplier done level (may stay high for many cycles)
//   product_in - multiplier product, stable while done is high
//   busy       - high while a conversion is in progress (CONV and FINISH)
//   bcd_valid  - one-cycle pulse when bcd_out updates
//   bcd_out    - packed BCD result, ones digit in [3:0], held between results
//   overrun    - sticky, set when a pending capture is overwritten
module product_bcd_converter
    import product_bcd_converter_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DIGITS = DEF_DIGITS,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset_a,
    input  logic                  done,
    input  logic [WIDTH-1:0]      product_in,
    output logic                  busy,
    output logic                  bcd_valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overrun
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t               state;
    logic                 done_q;
    logic                 pending;
    logic [WIDTH-1:0]     pend_data;
    logic [WIDTH-1:0]     bin_sr;
    logic [BCD_W-1:0]     bcd_work;
    logic [BCD_W-1:0]     bcd_adj;
    logic [CNT_W-1:0]     cnt;
    logic [BCD_W+WIDTH-1:0] shifted;
    logic                 start_evt;

    // A held-high done level produces exactly one event.
    assign start_evt = done & ~done_q;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (bcd_work[4*i +: 4]),
            .digit_out (bcd_adj[4*i +: 4])
        );
    end

    // Correct every digit first, then shift the whole {bcd, binary} pair left.
    assign shifted = {bcd_adj, bin_sr} << 1;

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state     <= ST_IDLE;
            done_q    <= 1'b0;
            pending   <= 1'b0;
            pend_data <= '0;
            bin_sr    <= '0;
            bcd_work  <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            bcd_valid <= 1'b0;
            bcd_out   <= '0;
            overrun   <= 1'b0;
        end else begin
            done_q    <= done;
            bcd_valid <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (pending) begin
                        // Parked capture goes first; a fresh event in the same
                        // cycle takes its place in the pending slot.
                        bin_sr   <= pend_data;
                        bcd_work <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= ST_CONV;
                        if (start_evt) begin
                            pend_data <= product_in;
                        end else begin
                            pending <= 1'b0;
                        end
                    end else if (start_evt) begin
                        bin_sr   <= product_in;
                        bcd_work <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= ST_CONV;
                    end
                end

                ST_CONV: begin
                    bcd_work <= shifted[BCD_W+WIDTH-1:WIDTH];
                    bin_sr   <= shifted[WIDTH-1:0];
                    cnt      <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= ST_FINISH;
                    end
                end

                ST_FINISH: begin
                    bcd_out   <= bcd_work;
                    bcd_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase

            // Events outside IDLE (including the FINISH cycle) are parked.
            if (start_evt && (state != ST_IDLE)) begin
                pend_data <= product_in;
                pending   <= 1'b1;
                if (pending) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule
